// File: rtl/bicubic_src_loader.sv
// rtl/bicubic_src_loader.sv - frame buffer loader, config latch and source-read server for the bicubic scaler
`timescale 1ns/1ps
module bicubic_src_loader #(
  parameter int IMG_W = 100,
  parameter int IMG_H = 100,
  parameter int AW    = 14
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sof,
  input  logic [7:0]    in_pixel,
  input  logic [6:0]    cfg_V0,
  input  logic [6:0]    cfg_H0,
  input  logic [4:0]    cfg_SW,
  input  logic [4:0]    cfg_SH,
  input  logic [5:0]    cfg_TW,
  input  logic [5:0]    cfg_TH,
  output logic [6:0]    V0,
  output logic [6:0]    H0,
  output logic [4:0]    SW,
  output logic [4:0]    SH,
  output logic [5:0]    TW,
  output logic [5:0]    TH,
  output logic          enable,
  input  logic          ird,
  input  logic [AW-1:0] iaddr,
  output logic [7:0]    input_data,
  input  logic          DONE,
  output logic          busy,
  output logic          frame_done,
  output logic          cfg_err,
  output logic          sync_err
);

  localparam int DEPTH = IMG_W * IMG_H;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ARM, ST_RUN} state_t;

  state_t        state_q;
  logic [AW:0]   wcnt_q;
  logic [AW:0]   wcnt_d;
  logic          in_ready_q;
  logic          enable_q;
  logic          busy_q;
  logic          frame_done_q;
  logic          cfg_err_q;
  logic          sync_err_q;
  logic          run_first_q;
  logic [7:0]    data_q;
  logic [6:0]    v0_q;
  logic [6:0]    h0_q;
  logic [4:0]    sw_q;
  logic [4:0]    sh_q;
  logic [5:0]    tw_q;
  logic [5:0]    th_q;

  logic [7:0]    mem_q [DEPTH];

  logic          accept;
  logic          wr_en;
  logic [AW-1:0] waddr;
  logic          last_beat;
  logic [7:0]    v_sum;
  logic [7:0]    h_sum;
  logic          cfg_ok;
  logic          rd_oob;

  always_comb begin
    accept    = in_valid && in_ready_q;
    wr_en     = accept && (((state_q == ST_IDLE) && in_sof) || (state_q == ST_LOAD));
    // a start-of-frame beat always lands at address 0, whatever the counter says
    waddr     = in_sof ? '0 : wcnt_q[AW-1:0];
    wcnt_d    = in_sof ? (AW+1)'(1) : wcnt_q + 1'b1;
    last_beat = (32'(wcnt_d) == DEPTH);
    v_sum     = {1'b0, cfg_V0} + {3'b000, cfg_SH};
    h_sum     = {1'b0, cfg_H0} + {3'b000, cfg_SW};
    cfg_ok    = (32'(v_sum) <= IMG_H) && (32'(h_sum) <= IMG_W) &&
                (|cfg_SW) && (|cfg_SH) && (|cfg_TW) && (|cfg_TH);
    rd_oob    = (32'(iaddr) >= DEPTH);
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[waddr] <= in_pixel;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      wcnt_q       <= '0;
      in_ready_q   <= 1'b1;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      sync_err_q   <= 1'b0;
      run_first_q  <= 1'b0;
      data_q       <= 8'h00;
      v0_q         <= '0;
      h0_q         <= '0;
      sw_q         <= '0;
      sh_q         <= '0;
      tw_q         <= '0;
      th_q         <= '0;
    end else begin
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;

      // old contents are returned when a read meets a write to the same address
      if (ird) begin
        data_q <= rd_oob ? 8'h00 : mem_q[iaddr];
        if (rd_oob) begin
          sync_err_q <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (in_sof) begin
              wcnt_q <= wcnt_d;
              busy_q <= 1'b1;
              if (last_beat) begin
                state_q    <= ST_ARM;
                in_ready_q <= 1'b0;
              end else begin
                state_q <= ST_LOAD;
              end
            end else begin
              sync_err_q <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (accept) begin
            if (in_sof) begin
              sync_err_q <= 1'b1;
            end
            wcnt_q <= wcnt_d;
            if (last_beat) begin
              state_q    <= ST_ARM;
              in_ready_q <= 1'b0;
            end
          end
        end

        ST_ARM: begin
          v0_q   <= cfg_V0;
          h0_q   <= cfg_H0;
          sw_q   <= cfg_SW;
          sh_q   <= cfg_SH;
          tw_q   <= cfg_TW;
          th_q   <= cfg_TH;
          wcnt_q <= '0;
          if (cfg_ok) begin
            state_q     <= ST_RUN;
            enable_q    <= 1'b1;
            run_first_q <= 1'b1;
          end else begin
            state_q    <= ST_IDLE;
            cfg_err_q  <= 1'b1;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end

        ST_RUN: begin
          // DONE may still be high from the previous frame on the first RUN cycle
          if (run_first_q) begin
            run_first_q <= 1'b0;
          end else if (DONE) begin
            state_q      <= ST_IDLE;
            enable_q     <= 1'b0;
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b1;
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          enable_q   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign enable     = enable_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;
  assign sync_err   = sync_err_q;
  assign input_data = data_q;
  assign V0         = v0_q;
  assign H0         = h0_q;
  assign SW         = sw_q;
  assign SH         = sh_q;
  assign TW         = tw_q;
  assign TH         = th_q;

endmodule

// File: tb/tb_bicubic_src_loader.sv
// tb/tb_bicubic_src_loader.sv - self-checking bench for bicubic_src_loader
`timescale 1ns/1ps
module tb_bicubic_src_loader;

  localparam int IMG_W = 100;
  localparam int IMG_H = 100;
  localparam int AW    = 14;
  localparam int DEPTH = IMG_W * IMG_H;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          in_valid;
  logic          in_ready;
  logic          in_sof;
  logic [7:0]    in_pixel;
  logic [6:0]    cfg_V0, cfg_H0;
  logic [4:0]    cfg_SW, cfg_SH;
  logic [5:0]    cfg_TW, cfg_TH;
  logic [6:0]    V0, H0;
  logic [4:0]    SW, SH;
  logic [5:0]    TW, TH;
  logic          enable;
  logic          ird;
  logic [AW-1:0] iaddr;
  logic [7:0]    input_data;
  logic          DONE;
  logic          busy;
  logic          frame_done;
  logic          cfg_err;
  logic          sync_err;

  bicubic_src_loader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_pixel(in_pixel),
    .cfg_V0(cfg_V0), .cfg_H0(cfg_H0), .cfg_SW(cfg_SW), .cfg_SH(cfg_SH),
    .cfg_TW(cfg_TW), .cfg_TH(cfg_TH),
    .V0(V0), .H0(H0), .SW(SW), .SH(SH), .TW(TW), .TH(TH),
    .enable(enable), .ird(ird), .iaddr(iaddr), .input_data(input_data),
    .DONE(DONE), .busy(busy), .frame_done(frame_done),
    .cfg_err(cfg_err), .sync_err(sync_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       ird;
    int         addr;
    logic [7:0] exp_data;
    logic       exp_serr;
  } rd_vec_t;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] ref_mem [DEPTH];
  int         mcnt     = 0;
  logic [7:0] sb_q [$];
  rd_vec_t    rd_tab [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic beat(input logic sof, input logic [7:0] pix);
    in_valid = 1'b1;
    in_sof   = sof;
    in_pixel = pix;
    if (sof) mcnt = 0;
    ref_mem[mcnt] = pix;
    mcnt++;
    tick();
    in_sof = 1'b0;
  endtask

  task automatic sb_check(input string name);
    logic [7:0] e;
    if (sb_q.size() == 0) begin
      chk({name, "_sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk(name, 32'(input_data), 32'(e));
    end
  endtask

  task automatic model_read(input int addr, input string name);
    ird   = 1'b1;
    iaddr = AW'(addr);
    sb_q.push_back(ref_mem[addr]);
    tick();
    ird = 1'b0;
    sb_check(name);
  endtask

  task automatic set_cfg(input int v0, input int h0, input int sw, input int sh,
                         input int tw, input int th);
    cfg_V0 = 7'(v0); cfg_H0 = 7'(h0); cfg_SW = 5'(sw);
    cfg_SH = 5'(sh); cfg_TW = 6'(tw); cfg_TH = 6'(th);
  endtask

  task automatic finish_frame(input string tag);
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    chk({tag, "_frame_done"}, 32'(frame_done), 1);
    chk({tag, "_enable_off"}, 32'(enable), 0);
    chk({tag, "_busy_off"}, 32'(busy), 0);
    tick();
    chk({tag, "_frame_done_pulse"}, 32'(frame_done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = 8'h00;
    ird = 1'b0; iaddr = '0; DONE = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);

    rd_tab[0] = '{1'b1, 2030,  8'hEE, 1'b0};
    rd_tab[1] = '{1'b1, 0,     8'h00, 1'b0};
    rd_tab[2] = '{1'b1, 255,   8'hFF, 1'b0};
    rd_tab[3] = '{1'b1, 9999,  8'h0F, 1'b0};
    rd_tab[4] = '{1'b1, 10000, 8'h00, 1'b1};
    rd_tab[5] = '{1'b0, 5,     8'h00, 1'b1};

    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_enable", 32'(enable), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sync_err", 32'(sync_err), 0);
    chk("rst_input_data", 32'(input_data), 0);
    chk("rst_V0", 32'(V0), 0);
    RST_N = 1'b1;
    tick();

    // full frame, valid config, reads, DONE
    set_cfg(20, 30, 13, 13, 25, 25);
    beat(1'b1, 8'h00);
    chk("a_busy_load", 32'(busy), 1);
    for (int i = 1; i < DEPTH - 1; i++) beat(1'b0, 8'(i));
    chk("a_pre_last_ready", 32'(in_ready), 1);
    beat(1'b0, 8'(DEPTH - 1));
    in_valid = 1'b0;
    chk("a_arm_ready", 32'(in_ready), 0);
    chk("a_arm_busy", 32'(busy), 1);
    chk("a_arm_enable", 32'(enable), 0);
    DONE = 1'b1;
    tick();
    chk("a_run_enable", 32'(enable), 1);
    chk("a_V0", 32'(V0), 20);
    chk("a_H0", 32'(H0), 30);
    chk("a_SW", 32'(SW), 13);
    chk("a_TH", 32'(TH), 25);
    tick();
    DONE = 1'b0;
    chk("a_first_run_ignores_done", 32'(enable), 1);
    chk("a_first_run_no_fd", 32'(frame_done), 0);

    for (int i = 0; i < 6; i++) begin
      ird   = rd_tab[i].ird;
      iaddr = AW'(rd_tab[i].addr);
      sb_q.push_back(rd_tab[i].exp_data);
      tick();
      sb_check($sformatf("rd_data[%0d]", i));
      chk($sformatf("rd_serr[%0d]", i), 32'(sync_err), 32'(rd_tab[i].exp_serr));
    end
    ird = 1'b0;
    chk("a_enable_during_reads", 32'(enable), 1);
    finish_frame("a");

    // asynchronous reset clears sticky/latched values without a clock edge
    #2 RST_N = 1'b0;
    #1;
    chk("r1_sync_err", 32'(sync_err), 0);
    chk("r1_V0", 32'(V0), 0);
    chk("r1_input_data", 32'(input_data), 0);
    tick();
    RST_N = 1'b1;
    tick();

    // frame restart mid-load, then boundary-valid config
    set_cfg(69, 87, 13, 31, 1, 1);
    beat(1'b1, 8'd7);
    for (int i = 1; i < 500; i++) beat(1'b0, 8'(i + 7));
    chk("rs_no_serr_yet", 32'(sync_err), 0);
    beat(1'b1, 8'h55);
    chk("rs_sync_err", 32'(sync_err), 1);
    chk("rs_still_ready", 32'(in_ready), 1);
    for (int k = 1; k < DEPTH - 1; k++) begin
      if (k == 10) begin
        // read-before-write at the address being written this cycle
        ird   = 1'b1;
        iaddr = AW'(10);
        sb_q.push_back(ref_mem[10]);
        beat(1'b0, 8'(k * 3));
        ird = 1'b0;
        sb_check("rs_rbw");
      end else begin
        beat(1'b0, 8'(k * 3));
      end
    end
    chk("rs_pre_last_ready", 32'(in_ready), 1);
    beat(1'b0, 8'((DEPTH - 1) * 3));
    in_valid = 1'b0;
    chk("rs_arm_ready", 32'(in_ready), 0);
    tick();
    chk("rs_run_enable", 32'(enable), 1);
    chk("rs_H0", 32'(H0), 87);
    chk("rs_SH", 32'(SH), 31);
    model_read(0, "rs_rd0");
    model_read(499, "rs_rd499");
    model_read(9999, "rs_rd9999");
    finish_frame("rs");

    #2 RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();

    // stray beats in IDLE, then a normal frame with a rejected config
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sof = 1'b0; in_pixel = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("sy_sync_err", 32'(sync_err), 1);
    chk("sy_busy_idle", 32'(busy), 0);
    chk("sy_ready_idle", 32'(in_ready), 1);
    set_cfg(0, 90, 17, 5, 4, 4);
    beat(1'b1, 8'h00);
    for (int i = 1; i < DEPTH - 1; i++) beat(1'b0, 8'(i));
    chk("cf_pre_last_ready", 32'(in_ready), 1);
    beat(1'b0, 8'(DEPTH - 1));
    in_valid = 1'b0;
    chk("cf_arm_ready", 32'(in_ready), 0);
    tick();
    chk("cf_cfg_err", 32'(cfg_err), 1);
    chk("cf_enable", 32'(enable), 0);
    chk("cf_busy", 32'(busy), 0);
    chk("cf_H0", 32'(H0), 90);
    chk("cf_SW", 32'(SW), 17);
    tick();
    chk("cf_cfg_err_pulse", 32'(cfg_err), 0);
    chk("cf_enable_stays", 32'(enable), 0);

    // reset in the middle of a load
    beat(1'b1, 8'h00);
    for (int i = 1; i < 4000; i++) beat(1'b0, 8'(i));
    in_valid = 1'b0;
    chk("mr_busy_before", 32'(busy), 1);
    #2 RST_N = 1'b0;
    #1;
    chk("mr_busy_async", 32'(busy), 0);
    chk("mr_ready_async", 32'(in_ready), 1);
    chk("mr_sync_err_async", 32'(sync_err), 0);
    tick();
    RST_N = 1'b1;
    tick();
    set_cfg(20, 30, 13, 13, 25, 25);
    beat(1'b1, 8'h00);
    for (int i = 1; i < DEPTH - 1; i++) beat(1'b0, 8'(i));
    chk("mr_pre_last_ready", 32'(in_ready), 1);
    beat(1'b0, 8'(DEPTH - 1));
    in_valid = 1'b0;
    chk("mr_arm_ready", 32'(in_ready), 0);
    tick();
    chk("mr_run_enable", 32'(enable), 1);
    tick();
    model_read(4321, "mr_rd4321");
    finish_frame("mr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bicubic_src_loader.md
Name: bicubic_src_loader

Overview:
- Upstream stage of the bicubic scaler: accepts a raster-order 8-bit pixel stream and stores one IMG_W x IMG_H source frame in an internal buffer.
- Latches and validates the scaler's geometry configuration.
- Launches the scaler, then serves its source-read port with fixed 1-cycle read latency until the scaler raises DONE.

Parameters:
- IMG_W, 100, source frame width in pixels
- IMG_H, 100, source frame height in pixels
- AW, 14, buffer address width; IMG_W*IMG_H must not exceed 2^AW

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST_N  in  1  asynchronous active-low reset
- in_valid  in  1  stream beat valid
- in_ready  out  1  stream beat accepted when in_valid && in_ready
- in_sof  in  1  marks first pixel (row 0, col 0) of a frame
- in_pixel  in  8  pixel value
- cfg_V0, cfg_H0  in  7  requested crop origin (row, col)
- cfg_SW, cfg_SH  in  5  requested crop width, height
- cfg_TW, cfg_TH  in  6  requested target width, height
- V0, H0  out  7  latched crop origin to scaler
- SW, SH  out  5  latched crop size to scaler
- TW, TH  out  6  latched target size to scaler
- enable  out  1  scaler run enable
- ird  in  1  scaler read strobe
- iaddr  in  AW  scaler read address (row*IMG_W + col)
- input_data  out  8  read data to scaler
- DONE  in  1  scaler frame complete
- busy  out  1  high in every state except IDLE
- frame_done  out  1  1-cycle pulse, scaler finished a frame
- cfg_err  out  1  1-cycle pulse, configuration rejected
- sync_err  out  1  sticky; cleared only by reset

Behaviour:
- Reset values:
  - in_ready=1, enable=0, busy=0, frame_done=0, cfg_err=0, sync_err=0.
  - input_data=0; V0, H0, SW, SH, TW, TH all 0.
  - Write counter 0; state IDLE.
  - Buffer contents are undefined after reset.
- States: IDLE, LOAD, ARM, RUN.
- IDLE:
  - in_ready=1.
  - An accepted beat with in_sof=1 writes address 0, sets the counter to 1 and goes to LOAD.
  - An accepted beat with in_sof=0 is discarded and sets sync_err.
- LOAD:
  - in_ready=1. Each accepted beat writes buffer[counter], then increments the counter.
  - An accepted beat with in_sof=1 sets sync_err, writes address 0 and sets the counter to 1 (frame restart).
  - Acceptance of beat number IMG_W*IMG_H (counter reaching 10000 at defaults) goes to ARM on the next edge.
- ARM (exactly 1 cycle):
  - in_ready=0. cfg_* are registered into V0..TH.
  - The configuration is valid iff all of the following hold:
    - cfg_V0 + cfg_SH <= IMG_H
    - cfg_H0 + cfg_SW <= IMG_W
    - cfg_SW, cfg_SH, cfg_TW, cfg_TH are all nonzero
  - The sums are computed at 8 bits, with no wrap.
  - Valid: go to RUN.
  - Invalid: pulse cfg_err for 1 cycle and return to IDLE; enable is never asserted.
- RUN:
  - in_ready=0; enable=1; V0..TH held constant.
  - The first cycle in RUN ignores DONE.
  - From the second RUN cycle on, DONE=1 causes: enable=0 on the next edge, a frame_done pulse for 1 cycle, and a return to IDLE.
- Read port:
  - Synchronous. If ird=1 at edge t, input_data after edge t = buffer[iaddr sampled at t], valid for the whole following cycle.
  - If ird=0, input_data holds its previous value.
  - Reads are serviced in every state. Buffer contents are only guaranteed in RUN.
  - iaddr >= IMG_W*IMG_H while ird=1 returns 0 and sets sync_err.
- Simultaneous write and read in LOAD to the same address: the read returns the old contents (read-before-write).
- No write occurs while in_ready=0.
- Reset asserted mid-operation:
  - All outputs go immediately (asynchronously) to their reset values; state goes to IDLE.
  - The partially loaded frame is abandoned; a new frame must start with in_sof.
- busy=1 in LOAD, ARM and RUN.

Test Plan:
- Load 10000 beats, pixel = addr mod 256, sof on first. Config V0=20, H0=30, SW=13, SH=13, TW=25, TH=25 -> ARM, RUN, enable=1, V0=20 latched.
  - Then ird=1, iaddr=2030 -> input_data=0xEE on the following cycle.
  - DONE=1 -> frame_done pulse, enable=0, busy=0.
- 5 beats with in_sof=0 in IDLE -> all discarded, sync_err=1, state stays IDLE, a later sof frame loads normally.
- Restart: 500 beats, then a beat with sof=1 and pixel 0x55 -> sync_err=1, buffer[0]=0x55, 10000 further beats required before ARM.
- Config H0=90, SW=17 after a full load -> cfg_err 1-cycle pulse, enable stays 0, return to IDLE, V0..TH show the rejected values.
- Read addresses 9999 then 10000 with ird=1 -> data for 9999 (0x0F at the above pattern), then 0x00 with sync_err=1.
  - ird=0 on the next cycle -> input_data stays 0x00.
- RST_N low at counter 4000 in LOAD -> in_ready=1, busy=0 immediately; with RST_N high, a fresh sof frame completes with exactly 10000 beats.
